// File: rtl/fetch_pc_queue.sv
// Front-end PC generator: produces sequential or predicted fetch PCs and buffers
// them in a DEPTH-entry FIFO handed to the i_cache through a valid/ready handshake.
module fetch_pc_queue #(
   parameter int                    ADDR_WIDTH  = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
   parameter int                    DEPTH       = 4,
   parameter int                    INSTR_BYTES = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_stall,
   input  logic                         i_redirect_valid,
   input  logic [ADDR_WIDTH-1:0]        i_redirect_pc,
   output logic [ADDR_WIDTH-1:0]        o_lookup_pc,
   input  logic                         i_pred_taken,
   input  logic [ADDR_WIDTH-1:0]        i_pred_target,
   output logic                         o_valid,
   output logic [ADDR_WIDTH-1:0]        o_pc,
   output logic                         o_pred_taken,
   input  logic                         i_ready,
   output logic [$clog2(DEPTH+1)-1:0]   o_count
);

   localparam int                    PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int                    CNT_W      = $clog2(DEPTH + 1);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(INSTR_BYTES - 1));
   localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(INSTR_BYTES);

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] pc;
      logic                  taken;
   } entry_t;

   entry_t                mem [DEPTH];
   logic [PTR_W-1:0]      rd_ptr, wr_ptr;
   logic [ADDR_WIDTH-1:0] gen_pc, gen_pc_next;
   logic [ADDR_WIDTH-1:0] hold_pc;
   logic                  hold_taken;
   logic                  pop, push;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      pop         = 1'b0;
      push        = 1'b0;
      gen_pc_next = gen_pc;
      if (!i_redirect_valid) begin
         pop  = o_valid && i_ready;
         push = !i_stall && ((o_count < CNT_W'(DEPTH)) || pop);
      end
      if (push)
         gen_pc_next = i_pred_taken ? (i_pred_target & ALIGN_MASK) : gen_pc + STEP;
   end

   assign o_valid      = (o_count != '0);
   assign o_lookup_pc  = gen_pc;
   // When empty, show the last presented head so the outputs never go unknown.
   assign o_pc         = o_valid ? mem[rd_ptr].pc    : hold_pc;
   assign o_pred_taken = o_valid ? mem[rd_ptr].taken : hold_taken;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         gen_pc     <= RESET_PC;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         o_count    <= '0;
         hold_pc    <= RESET_PC;
         hold_taken <= 1'b0;
      end else begin
         hold_pc    <= o_pc;
         hold_taken <= o_pred_taken;
         if (i_redirect_valid) begin
            gen_pc  <= i_redirect_pc & ALIGN_MASK;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            o_count <= '0;
         end else begin
            gen_pc <= gen_pc_next;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            o_count <= o_count + CNT_W'(push) - CNT_W'(pop);
         end
      end
   end

   // NOTE: the storage array is not reset; o_count alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (push && !rst)
         mem[wr_ptr] <= '{pc: gen_pc, taken: i_pred_taken};
   end

endmodule

// File: tb/tb_fetch_pc_queue.sv
// Self-checking bench for fetch_pc_queue: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_fetch_pc_queue;

   localparam int AW    = 32;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_stall;
   logic          i_redirect_valid;
   logic [AW-1:0] i_redirect_pc;
   logic [AW-1:0] o_lookup_pc;
   logic          i_pred_taken;
   logic [AW-1:0] i_pred_target;
   logic          o_valid;
   logic [AW-1:0] o_pc;
   logic          o_pred_taken;
   logic          i_ready;
   logic [2:0]    o_count;

   fetch_pc_queue #(.ADDR_WIDTH(AW), .RESET_PC('0), .DEPTH(DEPTH), .INSTR_BYTES(4)) dut (
      .clk(clk), .rst(rst), .i_stall(i_stall),
      .i_redirect_valid(i_redirect_valid), .i_redirect_pc(i_redirect_pc),
      .o_lookup_pc(o_lookup_pc), .i_pred_taken(i_pred_taken), .i_pred_target(i_pred_target),
      .o_valid(o_valid), .o_pc(o_pc), .o_pred_taken(o_pred_taken),
      .i_ready(i_ready), .o_count(o_count)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%h expected=0x%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the fetch queue is a plain SV queue of {pc, taken}.
   typedef struct {
      logic [AW-1:0] pc;
      logic          taken;
   } ent_t;

   ent_t          m_q[$];
   logic [AW-1:0] m_gen;
   bit            m_live     = 0;
   bit            m_from_rst = 0;

   function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
      return {a[AW-1:2], 2'b00};
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_q.delete();
         m_gen      = '0;
         m_live     = 1;
         m_from_rst = 1;
      end else if (m_live) begin
         if (i_redirect_valid) begin
            m_q.delete();
            m_gen = align(i_redirect_pc);
         end else begin
            bit do_pop, do_push;
            do_pop  = (m_q.size() > 0) && i_ready;
            do_push = !i_stall && ((m_q.size() < DEPTH) || do_pop);
            if (do_pop) void'(m_q.pop_front());
            if (do_push) begin
               m_q.push_back('{pc: m_gen, taken: i_pred_taken});
               m_gen = i_pred_taken ? align(i_pred_target) : m_gen + 32'd4;
            end
         end
         if (m_q.size() > 0) m_from_rst = 0;
      end
   end

   // Single compare process against the model, away from the active edge.
   always @(negedge clk) begin
      if (m_live) begin
         check("count", AW'(o_count), AW'(m_q.size()));
         check("valid", AW'(o_valid), AW'(m_q.size() > 0));
         check("lookup_pc", o_lookup_pc, m_gen);
         check("pc_known", AW'($isunknown({o_pc, o_pred_taken})), '0);
         if (m_q.size() > 0) begin
            check("head_pc", o_pc, m_q[0].pc);
            check("head_taken", AW'(o_pred_taken), AW'(m_q[0].taken));
         end else if (m_from_rst) begin
            check("reset_taken", AW'(o_pred_taken), '0);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input logic ready);
      rst = 0; i_stall = 0; i_redirect_valid = 0; i_redirect_pc = '0;
      i_pred_taken = 0; i_pred_target = '0; i_ready = ready;
   endtask

   task automatic do_reset();
      idle(1'b0);
      rst = 1;
      cyc();
      rst = 0;
   endtask

   initial begin
      logic [AW-1:0] exp_pc [5];

      idle(1'b0);
      rst = 1;
      cyc();
      cyc();
      check("rst_valid", AW'(o_valid), '0);
      check("rst_count", AW'(o_count), '0);
      check("rst_lookup", o_lookup_pc, '0);
      check("rst_taken", AW'(o_pred_taken), '0);

      // Streaming from reset: 0x0, 0x4, 0x8, 0xC on consecutive cycles.
      rst = 0; i_ready = 1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         check("t1_valid", AW'(o_valid), 1);
         check("t1_pc", o_pc, AW'(4 * i));
      end

      // Fill with i_ready low, then drain without gaps.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         cyc();
         check("t2_fill_count", AW'(o_count), AW'((i < 4) ? i + 1 : 4));
      end
      check("t2_lookup_full", o_lookup_pc, 32'h10);
      check("t2_head_full", o_pc, 32'h0);
      i_ready = 1;
      for (int i = 0; i < 5; i++) begin
         check("t2_stream_pc", o_pc, AW'(4 * i));
         check("t2_stream_count", AW'(o_count), 4);
         cyc();
      end

      // Predicted-taken branch at 0x8 redirects generation to 0x40.
      do_reset();
      i_ready = 1;
      exp_pc = '{32'h0, 32'h4, 32'h8, 32'h40, 32'h44};
      for (int i = 0; i < 5; i++) begin
         i_pred_taken  = (m_gen == 32'h8);
         i_pred_target = 32'h40;
         cyc();
         check("t3_pc", o_pc, exp_pc[i]);
         check("t3_taken", AW'(o_pred_taken), AW'(i == 2));
      end

      // Redirect to an unaligned target while stalled, with 3 entries queued.
      do_reset();
      for (int i = 0; i < 3; i++) cyc();
      check("t4_count_before", AW'(o_count), 3);
      i_stall = 1; i_redirect_valid = 1; i_redirect_pc = 32'h103; i_ready = 1;
      cyc();
      check("t4_valid_flush", AW'(o_valid), '0);
      check("t4_count_flush", AW'(o_count), '0);
      check("t4_lookup", o_lookup_pc, 32'h100);
      i_redirect_valid = 0;
      cyc();
      check("t4_valid_stalled", AW'(o_valid), '0);
      i_stall = 0;
      cyc();
      check("t4_first_pc", o_pc, 32'h100);
      cyc();
      check("t4_second_pc", o_pc, 32'h104);

      // Address wrap past the top of the address space.
      i_redirect_valid = 1; i_redirect_pc = 32'hFFFF_FFF8;
      cyc();
      i_redirect_valid = 0;
      exp_pc = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8};
      for (int i = 0; i < 4; i++) begin
         cyc();
         check("t5_pc", o_pc, exp_pc[i]);
      end

      // Reset beats a simultaneous redirect on a full queue.
      do_reset();
      for (int i = 0; i < 5; i++) cyc();
      check("t6_full", AW'(o_count), 4);
      rst = 1; i_redirect_valid = 1; i_redirect_pc = 32'h200;
      cyc();
      check("t6_valid", AW'(o_valid), '0);
      check("t6_count", AW'(o_count), '0);
      check("t6_lookup", o_lookup_pc, '0);
      idle(1'b1);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         rst              = ($urandom_range(0, 199) == 0);
         i_redirect_valid = ($urandom_range(0, 19) == 0);
         i_redirect_pc    = $urandom();
         i_stall          = ($urandom_range(0, 3) == 0);
         i_ready          = ($urandom_range(0, 9) < 6);
         i_pred_taken     = ($urandom_range(0, 6) == 0);
         i_pred_target    = $urandom();
         cyc();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
